// File: rtl/sad_stream_trigger.sv
// sad_stream_trigger: staggered-accumulator SAD matcher, one full window evaluated per ADC clock.
// Optional per-index reference exclusion is built when SAD_EXCLUDE_EN is defined.
module sad_stream_trigger #(
  parameter int pREF_SAMPLES = 32,
  parameter int pBITS_PER_SAMPLE = 12,
  parameter int pSUM_BITS = pBITS_PER_SAMPLE + $clog2(pREF_SAMPLES)
) (
  input  logic                            clk_adc,
  input  logic                            reset_n,
  input  logic [pBITS_PER_SAMPLE-1:0]     adc_datain,
  input  logic                            armed_and_ready,
  input  logic                            ref_we,
  input  logic [$clog2(pREF_SAMPLES)-1:0] ref_addr,
  input  logic [pBITS_PER_SAMPLE-1:0]     ref_data,
  input  logic                            ref_excl,
  input  logic [pSUM_BITS-1:0]            threshold,
  input  logic                            continuous,
  input  logic [15:0]                     holdoff,
  output logic                            trigger,
  output logic                            active,
  output logic [15:0]                     match_count
);
  localparam int n = pREF_SAMPLES;
  localparam int bw = pBITS_PER_SAMPLE;
  localparam int sw = pSUM_BITS;
  localparam int aw = $clog2(n);
  logic [bw-1:0] ref_mem [n];
  logic [bw-1:0] samp;
  logic [aw-1:0] samp_ph;
  logic samp_full, match_q, done, start, fire, active_d, wr;
  logic [15:0] hcnt;
  logic [sw-1:0] acc [n];
  logic [sw-1:0] acc_nx [n];
  logic [aw:0] idx [n];
  logic [bw-1:0] diff [n];
  logic [n-1:0] acc_done, keep;
  logic [sw-1:0] done_sum;
  assign wr = ref_we && !active && !start && ({1'b0, ref_addr} < (aw+1)'(n));
`ifdef SAD_EXCLUDE_EN
  logic [n-1:0] excl;
  always_ff @(posedge clk_adc or negedge reset_n)
    if (!reset_n) excl <= '0;
    else if (wr) excl[ref_addr] <= ref_excl;
  assign keep = ~excl;
`else
  logic unused_excl;
  assign unused_excl = ref_excl;
  assign keep = '1;
`endif
  // acc[j] pairs the registered sample of phase p with ref[(p-j) mod n]
  always_comb begin
    start = armed_and_ready && !active && !done;
    fire = active && armed_and_ready && match_q && (!continuous || hcnt == '0);
    active_d = start || (active && armed_and_ready && !(fire && !continuous));
    done_sum = '0;
    for (int j = 0; j < n; j++) begin
      idx[j] = ({1'b0, samp_ph} >= (aw+1)'(j)) ? {1'b0, samp_ph} - (aw+1)'(j) : {1'b0, samp_ph} + (aw+1)'(n - j);
      diff[j] = !keep[idx[j][aw-1:0]] ? '0 :
                samp >= ref_mem[idx[j][aw-1:0]] ? samp - ref_mem[idx[j][aw-1:0]] : ref_mem[idx[j][aw-1:0]] - samp;
      acc_nx[j] = acc[j] + sw'(diff[j]);
      acc_done[j] = idx[j] == (aw+1)'(n - 1);
      if (acc_done[j]) done_sum = acc_nx[j];
    end
  end
  always_ff @(posedge clk_adc or negedge reset_n)
    if (!reset_n) begin
      trigger <= 1'b0;
      active <= 1'b0;
      match_count <= '0;
      done <= 1'b0;
      match_q <= 1'b0;
      hcnt <= '0;
      samp <= '0;
      samp_ph <= '0;
      samp_full <= 1'b0;
      for (int j = 0; j < n; j++) begin
        acc[j] <= '0;
        ref_mem[j] <= '0;
      end
    end else begin
      active <= active_d;
      trigger <= fire;
      done <= armed_and_ready && (done || (fire && !continuous));
      hcnt <= fire ? holdoff : hcnt != '0 ? hcnt - 1'b1 : hcnt;
      match_count <= start ? '0 : (fire && match_count != '1) ? match_count + 1'b1 : match_count;
      samp <= adc_datain;
      samp_ph <= (start || samp_ph == aw'(n - 1)) ? '0 : samp_ph + 1'b1;
      samp_full <= !start && (samp_full || samp_ph == aw'(n - 2));
      match_q <= !start && active && samp_full && done_sum <= threshold;
      for (int j = 0; j < n; j++)
        acc[j] <= (start || acc_done[j]) ? '0 : active ? acc_nx[j] : acc[j];
      if (wr) ref_mem[ref_addr] <= ref_data;
    end
endmodule

// File: tb/tb_sad_stream_trigger.sv
// tb_sad_stream_trigger: randomized and directed stimulus against a window-level SAD reference model.
module tb_sad_stream_trigger;
  logic clk_adc = 1'b0;
  logic reset_n;
  logic [11:0] adc_datain, ref_data;
  logic armed_and_ready, ref_we, ref_excl, continuous;
  logic [2:0] ref_addr;
  logic [14:0] threshold;
  logic [15:0] holdoff;
  logic trigger, active;
  logic [15:0] match_count;
  int checks = 0, errors = 0;
  int e = 0, m_cnt, m_dead, smode = 0, cval = 0, off_at = -1;
  bit m_act, m_done, m_trig;
  int m_ref [8];
  bit m_excl [8];
  int win [$];
  bit cand [int];

  sad_stream_trigger #(.pREF_SAMPLES(8), .pBITS_PER_SAMPLE(12)) dut (
    .clk_adc(clk_adc), .reset_n(reset_n), .adc_datain(adc_datain),
    .armed_and_ready(armed_and_ready), .ref_we(ref_we), .ref_addr(ref_addr),
    .ref_data(ref_data), .ref_excl(ref_excl), .threshold(threshold),
    .continuous(continuous), .holdoff(holdoff), .trigger(trigger),
    .active(active), .match_count(match_count)
  );

  always #5 clk_adc = ~clk_adc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sad();
    int s = 0;
    for (int i = 0; i < 8; i++) begin
`ifdef SAD_EXCLUDE_EN
      if (m_excl[i]) continue;
`endif
      s += win[i] > m_ref[i] ? win[i] - m_ref[i] : m_ref[i] - win[i];
    end
    return s;
  endfunction

  function automatic void model_reset();
    m_act = 0; m_done = 0; m_trig = 0; m_cnt = 0; m_dead = -1;
    for (int i = 0; i < 8; i++) begin m_ref[i] = 0; m_excl[i] = 0; end
    win.delete();
    cand.delete();
  endfunction

  // Window ending at sample k matches -> pulse two edges later, subject to arm, mode and holdoff.
  function automatic void model_edge();
    bit arm, st, fi, an;
    arm = armed_and_ready;
    st = arm && !m_act && !m_done;
    fi = m_act && arm && cand.exists(e) && (!continuous || e > m_dead);
    if (cand.exists(e)) cand.delete(e);
    m_trig = fi;
    if (fi) begin
      m_dead = e + int'(holdoff);
      if (m_cnt < 65535) m_cnt++;
    end
    an = st || (m_act && arm && !(fi && !continuous));
    m_done = arm && (m_done || (fi && !continuous));
    if (st) begin m_cnt = 0; win.delete(); end
    if (an) begin
      win.push_back(int'(adc_datain));
      if (win.size() > 8) void'(win.pop_front());
      if (win.size() == 8 && sad() <= int'(threshold)) cand[e + 2] = 1;
    end else cand.delete();
    if (ref_we && !m_act && !st) begin
      m_ref[ref_addr] = int'(ref_data);
      m_excl[ref_addr] = ref_excl;
    end
    m_act = an;
    e++;
  endfunction

  task automatic tick();
    @(posedge clk_adc);
    model_edge();
    @(negedge clk_adc);
    check("trigger", trigger, m_trig);
    check("active", active, m_act);
    check("match_count", match_count, m_cnt);
  endtask

  function automatic logic [11:0] gen(int i);
    int v;
    case (smode)
      0: v = cval;
      1: v = (i >= 3 && i <= 10) ? m_ref[i-3] + (i == off_at ? 8 : 0) : 4095;
      2: v = (i % 8 == 3) ? 4095 : 100;
      default: v = m_ref[i % 8] + (($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : 0);
    endcase
    return v > 4095 ? 12'd4095 : 12'(v);
  endfunction

  task automatic idle(input int cyc);
    armed_and_ready = 0;
    ref_we = 0;
    repeat (cyc) tick();
  endtask

  task automatic write_ref(input int a, input int d, input bit x);
    ref_we = 1; ref_addr = 3'(a); ref_data = 12'(d); ref_excl = x;
    tick();
    ref_we = 0;
  endtask

  task automatic run(input int cyc, input int drop_at, output int rise);
    rise = -1;
    armed_and_ready = 1;
    for (int i = 0; i < cyc; i++) begin
      if (i == drop_at) armed_and_ready = 0;
      adc_datain = gen(i);
      tick();
      if (trigger && rise < 0) rise = i;
    end
  endtask

  initial begin
    int r, v, kind, len;
    reset_n = 0; adc_datain = 0; armed_and_ready = 0; ref_we = 0; ref_addr = 0;
    ref_data = 0; ref_excl = 0; threshold = 0; continuous = 0; holdoff = 0;
    model_reset();
    repeat (2) @(negedge clk_adc);
    check("rst_trigger", trigger, 0);
    check("rst_active", active, 0);
    check("rst_count", match_count, 0);
    #2 reset_n = 1;
    idle(1);
    for (int a = 0; a < 8; a++) write_ref(a, 100, 0);
    smode = 0; cval = 100;
    run(12, -1, r);
    check("single_latency", r, 9);
    check("single_count", match_count, 1);
    check("single_active", active, 0);
    idle(2);
    continuous = 1; holdoff = 5;
    run(30, -1, r);
    check("holdoff5_latency", r, 9);
    check("holdoff5_count", match_count, 4);
    idle(2);
    holdoff = 0;
    run(20, -1, r);
    check("holdoff0_count", match_count, 11);
    idle(2);
    continuous = 0;
    for (int a = 0; a < 8; a++) write_ref(a, a, 0);
    smode = 1;
    run(16, -1, r);
    check("ramp_latency", r, 12);
    idle(2);
    threshold = 7; off_at = 5;
    run(16, -1, r);
    check("ramp_off8", r, -1);
    idle(2);
    threshold = 0; off_at = -1;
    for (int a = 0; a < 8; a++) write_ref(a, 100, 0);
    smode = 0; cval = 100;
    run(12, 9, r);
    check("drop_no_trigger", r, -1);
    check("drop_active", active, 0);
    run(12, -1, r);
    check("rearm_latency", r, 9);
    idle(2);
    run(5, -1, r);
    #2 reset_n = 0;
    #1;
    check("async_rst_trigger", trigger, 0);
    check("async_rst_active", active, 0);
    check("async_rst_count", match_count, 0);
    model_reset();
    armed_and_ready = 0;
    @(negedge clk_adc);
    #2 reset_n = 1;
    cval = 0;
    run(12, -1, r);
    check("post_rst_latency", r, 9);
    idle(2);
    for (int a = 0; a < 8; a++) write_ref(a, 100, a == 3);
    smode = 2;
    run(12, -1, r);
`ifdef SAD_EXCLUDE_EN
    check("excl_latency", r, 9);
`else
    check("excl_latency", r, -1);
`endif
    idle(2);
    smode = 3;
    for (int p = 0; p < 60; p++) begin
      kind = $urandom_range(0, 2);
      threshold = 15'($urandom_range(0, 20));
      continuous = 1'($urandom_range(0, 1));
      holdoff = 16'($urandom_range(0, 12));
      v = $urandom_range(0, 4095);
      for (int a = 0; a < 8; a++)
        write_ref(a, kind == 0 ? v : int'($urandom_range(0, 4095)), $urandom_range(0, 3) == 0);
      len = $urandom_range(20, 60);
      armed_and_ready = 1;
      for (int i = 0; i < len; i++) begin
        if (kind == 2) armed_and_ready = ($urandom_range(0, 9) != 0);
        ref_we = ($urandom_range(0, 7) == 0);
        ref_addr = 3'($urandom);
        ref_data = 12'($urandom);
        ref_excl = 1'($urandom);
        adc_datain = gen(i);
        tick();
      end
      idle(2);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
